// File: rtl/multiplier_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, W cycles per product.
// Signed operands are converted to magnitudes on capture; the sign is reapplied on the final write.
module multiplier_iter #(
   parameter int W = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   product
);

   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [W-1:0]     ONE_W    = W'(1);
   localparam logic [2*W-1:0]   ONE_2W   = (2*W)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // |v| as an unsigned W-bit value; the most negative input maps to 2^(W-1).
   function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] v);
      magnitude = v[W-1] ? (~v + ONE_W) : v;
   endfunction

   function automatic logic [2*W-1:0] apply_sign(input logic [2*W-1:0] mag, input logic neg);
      apply_sign = neg ? (~mag + ONE_2W) : mag;
   endfunction

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic [W-1:0]        mcand_q, mcand_d;
   logic                neg_q, neg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*W-1:0]      acc_q, acc_d;
   logic [2*W-1:0]      product_q, product_d;
   logic [W:0]          sum;
   logic [2*W-1:0]      acc_step;

   // Upper half accumulates partial sums; lower half starts as the multiplier
   // and fills with finished product bits as it shifts right.
   always_comb begin
      sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
      acc_step = {sum, acc_q[W-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      product_d = product_q;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               cnt_d   = '0;
               state_d = RUN;
               if (signed_mode) begin
                  mcand_d = magnitude(a);
                  acc_d   = {{W{1'b0}}, magnitude(b)};
                  neg_d   = a[W-1] ^ b[W-1];
               end else begin
                  mcand_d = a;
                  acc_d   = {{W{1'b0}}, b};
                  neg_d   = 1'b0;
               end
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               product_d = apply_sign(acc_step, neg_q);
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered so that in_ready stays low through reset and for the first edge after it.
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         mcand_q    <= '0;
         neg_q      <= 1'b0;
         cnt_q      <= '0;
         acc_q      <= '0;
         product_q  <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         mcand_q    <= mcand_d;
         neg_q      <= neg_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         product_q  <= product_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule

// File: doc/multiplier_iter.md
MULTIPLIER_ITER -- requirements
Module: multiplier_iter

Interface
REQ-001 The block SHALL have parameter W, default 28, meaning the operand width in bits, legal range 2..64.
REQ-002 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-004 in_valid  input  1  SHALL mean the operand set is presented.
REQ-005 in_ready  output  1  SHALL mean the block can accept operands.
REQ-006 a  input  W  SHALL be the multiplicand.
REQ-007 b  input  W  SHALL be the multiplier.
REQ-008 signed_mode  input  1  SHALL select the operand format: 1 = two's complement, 0 = unsigned.
REQ-009 out_valid  output  1  SHALL mean the product is valid.
REQ-010 out_ready  input  1  SHALL mean the consumer takes the product.
REQ-011 product  output  2W  SHALL be the full-width product.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both SHALL be registered or decoded directly from state.
REQ-014 On a rising edge with state IDLE and in_valid=1, the block SHALL capture a, b and signed_mode, clear the accumulator and cycle counter, and go to RUN.
REQ-015 Operand capture in signed mode: the block SHALL store |a| and |b| as W-bit unsigned values plus the sign flag neg = a[W-1] XOR b[W-1]; |-2^(W-1)| = 2^(W-1) SHALL be representable without overflow.
REQ-016 Operand capture in unsigned mode: the block SHALL store a and b unchanged with neg=0.
REQ-017 RUN SHALL execute shift-add with one multiplier bit per cycle, LSB first, for exactly W rising edges; the counter SHALL be ceil(log2(W)) bits or wider.
REQ-018 On the W-th RUN edge, the block SHALL write the final 2W-bit magnitude into product, two's-complement negated if neg=1, and go to DONE.
REQ-019 Latency: with acceptance at edge E0, out_valid SHALL first be 1 after edge E0+W.
REQ-020 In DONE, product SHALL hold stable while out_ready=0, for any number of cycles.
REQ-021 On a rising edge with state DONE and out_ready=1, the block SHALL go to IDLE and keep product at its last value.
REQ-022 There SHALL be no bypass: a new acceptance is possible no earlier than the edge after the DONE handshake, giving a throughput of one product per W+2 cycles.
REQ-023 The block SHALL ignore in_valid, a, b and signed_mode in RUN and DONE; input changes in those states SHALL NOT affect the result in flight.
REQ-024 The block SHALL ignore out_ready outside DONE.
REQ-025 Zero operands SHALL still take the full W cycles; product SHALL be 0, with no negative zero, when either operand is 0.
REQ-026 The product SHALL be exact for all operand pairs in both modes; no truncation or saturation is permitted.

Reset
REQ-027 When rst=1, the block SHALL immediately force state to IDLE, with no dependence on clk.
REQ-028 When rst=1, the block SHALL immediately force in_ready=0, out_valid=0 and product=0.
REQ-029 When rst=1, the block SHALL immediately clear the accumulator, the counter and the operand and sign registers to 0.
REQ-030 After rst falls, in_ready SHALL be 1 in the first cycle following the next rising edge, and no handshake SHALL occur before that edge.
REQ-031 An rst assertion in RUN or DONE SHALL abort the operation; the aborted result SHALL never appear with out_valid=1.

Verification
REQ-032 The bench SHALL cover this scenario: W=28, unsigned, a=b=0xFFFFFFF -> product=0xFFFFFFE0000001, out_valid rising exactly 28 edges after acceptance.
REQ-033 The bench SHALL cover this scenario: W=28, signed, a=b=0x8000000 (-2^27) -> product=0x40000000000000; a=0xFFFFFFD (-3), b=5 -> product=0xFFFFFFFFFFFFF1.
REQ-034 The bench SHALL cover this scenario: W=28, signed, a=b=0xFFFFFFF -> product=1; the same operands unsigned -> 0xFFFFFFE0000001.
REQ-035 The bench SHALL cover this scenario: out_ready held 0 for 10 cycles in DONE while a, b and in_valid toggle -> product stable, in_ready=0, and exactly one handshake when out_ready rises.
REQ-036 The bench SHALL cover this scenario: rst pulsed mid-RUN (counter=13) -> outputs 0 asynchronously, no out_valid afterwards, and a next operation with a=7, b=6 -> 42.
REQ-037 The bench SHALL cover this scenario: W=8, 1000 back-to-back random operations in both modes against a reference model -> all products exact, with a spacing of 10 cycles per operation when out_ready=1.
